// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the external memory bus controller:
// access-length encodings, FSM states, requester ids and the UART address window.
package mem_ctrl_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int IF_BYTES   = 4;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd3;

    // Stores into this window go to the UART and must wait while its buffer is full
    localparam logic [1:0] IO_PREFIX = 2'b11;
    localparam int         IO_HI     = 17;
    localparam int         IO_LO     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_LS = 1'b1
    } src_e;

    // Encoding 2 is illegal and is served as a full word
    function automatic logic [2:0] ls_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response and memory-bus signals of mem_ctrl. The slave modport is the
// controller's view; the master modport is the view of the surrounding cpu/memory.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic                  rdy;
    logic                  clr;
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_done;
    logic [31:0]           if_data;
    logic                  ls_req;
    logic                  ls_wr;
    logic [1:0]            ls_len;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic [31:0]           ls_wdata;
    logic                  ls_done;
    logic [31:0]           ls_rdata;
    logic                  io_buffer_full;
    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic                  mem_wr;

    modport slave (
        input  rdy, clr, if_req, if_addr, ls_req, ls_wr, ls_len, ls_addr, ls_wdata,
               io_buffer_full, mem_din,
        output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

    modport master (
        output rdy, clr, if_req, if_addr, ls_req, ls_wr, ls_len, ls_addr, ls_wdata,
               io_buffer_full, mem_din,
        input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates the 8-bit external memory bus between instruction fetch and load/store,
// serialising each request into byte accesses and reassembling read data.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);

    state_e                state_q, state_d;
    src_e                  src_q, src_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [2:0]            n_q, n_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [2:0]            cap_q, cap_d;
    logic [31:0]           data_q, data_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [7:0]            mem_dout_q, mem_dout_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  if_done_q, if_done_d;
    logic                  ls_done_q, ls_done_d;
    logic [31:0]           if_data_q, if_data_d;
    logic [31:0]           ls_rdata_q, ls_rdata_d;
    logic                  ls_io_blocked;

    assign ls_io_blocked = bus.ls_wr && (bus.ls_addr[IO_HI:IO_LO] == IO_PREFIX)
                           && bus.io_buffer_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= SRC_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            n_q        <= '0;
            cnt_q      <= '0;
            cap_q      <= '0;
            data_q     <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
            data_q     <= data_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // cnt_q equals the cycle index inside a transaction; byte cnt_q-2 is on mem_din
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        cap_d      = cap_q;
        data_d     = data_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_done_d  = if_done_q;
        ls_done_d  = ls_done_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;

        if (bus.rdy) begin
            if_done_d = 1'b0;
            ls_done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    // A done pulse means the requester has not yet dropped its req
                    if (!if_done_q && !ls_done_q) begin
                        if (bus.ls_req && !ls_io_blocked) begin
                            state_d    = bus.ls_wr ? WRITE : READ;
                            src_d      = SRC_LS;
                            addr_d     = bus.ls_addr;
                            wdata_d    = bus.ls_wdata;
                            n_d        = ls_bytes(bus.ls_len);
                            cnt_d      = 3'd1;
                            cap_d      = '0;
                            data_d     = '0;
                            mem_a_d    = bus.ls_addr;
                            mem_wr_d   = bus.ls_wr;
                            mem_dout_d = bus.ls_wr ? bus.ls_wdata[7:0] : 8'h00;
                        end else if (bus.if_req && !bus.clr) begin
                            state_d    = READ;
                            src_d      = SRC_IF;
                            addr_d     = bus.if_addr;
                            n_d        = 3'(IF_BYTES);
                            cnt_d      = 3'd1;
                            cap_d      = '0;
                            data_d     = '0;
                            mem_a_d    = bus.if_addr;
                            mem_wr_d   = 1'b0;
                            mem_dout_d = 8'h00;
                        end
                    end
                end
                READ: begin
                    if (src_q == SRC_IF && bus.clr) begin
                        state_d = IDLE;
                        mem_a_d = '0;
                    end else begin
                        cnt_d   = cnt_q + 3'd1;
                        mem_a_d = (cnt_q < n_q) ? addr_q + ADDR_WIDTH'(cnt_q) : '0;
                        if (cnt_q >= 3'd2) begin
                            data_d[{cap_q[1:0], 3'b000} +: 8] = bus.mem_din;
                            cap_d = cap_q + 3'd1;
                            if (cap_q == n_q - 3'd1) begin
                                state_d = IDLE;
                                if (src_q == SRC_IF) begin
                                    if_done_d = 1'b1;
                                    if_data_d = data_d;
                                end else begin
                                    ls_done_d  = 1'b1;
                                    ls_rdata_d = data_d;
                                end
                            end
                        end
                    end
                end
                WRITE: begin
                    if (cnt_q < n_q) begin
                        cnt_d      = cnt_q + 3'd1;
                        mem_a_d    = addr_q + ADDR_WIDTH'(cnt_q);
                        mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                        mem_wr_d   = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        mem_a_d    = '0;
                        mem_dout_d = 8'h00;
                        mem_wr_d   = 1'b0;
                        ls_done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.mem_a    = mem_a_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.mem_wr   = mem_wr_q;
    assign bus.if_done  = if_done_q;
    assign bus.if_data  = if_data_q;
    assign bus.ls_done  = ls_done_q;
    assign bus.ls_rdata = ls_rdata_q;

endmodule
